// File: rtl/cache_wb_buffer_pkg.sv
// cache_wb_buffer_pkg: line geometry, FSM state encoding and burst constants for the writeback buffer
package cache_wb_buffer_pkg;
  localparam int LINE_W = 4;
  localparam int LINE_LOG_W = 2;
  localparam logic [3:0] WSTRB_FULL = 4'hf;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AW     = 2'd1,
    ST_W      = 2'd2,
    ST_B_WAIT = 2'd3
  } state_t;
  function automatic logic [7:0] burst_len(input int words);
    return 8'(words - 1);
  endfunction
endpackage

// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer: latches an evicted dirty line and writes it out as one W-beat memory burst
// Ports: clk/resetn (async active-low); wb_req_* / wb_addr / wb_line from the cache replace path;
// aw*/w*/b* burst write channels toward memory; busy while not idle; wb_done pulses after the response.
// Optional CACHE_WB_BRESP_CHECK_EN adds input bresp and a sticky error flag wb_err.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int W      = LINE_W,
  parameter int LOG_W  = LINE_LOG_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_req_valid,
  output logic              wb_req_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [32*W-1:0]   wb_line,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
`ifdef CACHE_WB_BRESP_CHECK_EN
  input  logic [1:0]        bresp,
  output logic              wb_err,
`endif
  output logic              busy,
  output logic              wb_done
);
  state_t state_q, state_d;
  logic [32*W-1:0] line_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LOG_W-1:0] cnt;
  logic last_beat;
  assign last_beat = cnt == LOG_W'(W - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == ST_IDLE ? (wb_req_valid ? ST_AW : ST_IDLE) :
              state_q == ST_AW   ? (awready ? ST_W : ST_AW) :
              state_q == ST_W    ? (wready && last_beat ? ST_B_WAIT : ST_W) :
                                   (bvalid ? ST_IDLE : ST_B_WAIT);
  always_comb begin
    wb_req_ready = state_q == ST_IDLE;
    busy         = state_q != ST_IDLE;
    awvalid      = state_q == ST_AW;
    wvalid       = state_q == ST_W;
    wlast        = wvalid && last_beat;
    wstrb        = wvalid ? WSTRB_FULL : 4'h0;
    bready       = state_q == ST_B_WAIT;
    awaddr       = addr_q;
    awlen        = burst_len(W);
    wdata        = line_q[32*cnt +: 32];
  end
  // The buffer is the sole copy of the line once accepted; the cache RAM may be reused next cycle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      line_q  <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      wb_done <= 1'b0;
    end else begin
      wb_done <= bready && bvalid;
      if (wb_req_valid && wb_req_ready) begin
        line_q <= wb_line;
        addr_q <= wb_addr & ~ADDR_W'(4 * W - 1);
      end
      if (awvalid && awready) cnt <= '0;
      else if (wvalid && wready) cnt <= cnt + 1'b1;
    end
`ifdef CACHE_WB_BRESP_CHECK_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) wb_err <= 1'b0;
    else if (bready && bvalid && bresp != 2'b00) wb_err <= 1'b1;
`endif
endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb_cache_wb_buffer: directed table-driven and sequence checks for cache_wb_buffer
module tb_cache_wb_buffer;
  localparam int W = 4;
  logic clk = 1'b0, resetn = 1'b1;
  logic wb_req_valid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] wb_addr = '0;
  logic [32*W-1:0] wb_line = '0;
  logic [1:0] bresp = 2'b00;
  logic wb_req_ready, awvalid, wvalid, wlast, bready, busy, wb_done;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [3:0] wstrb;
`ifdef CACHE_WB_BRESP_CHECK_EN
  logic wb_err;
`endif
  int ncmp = 0, nerr = 0;

  cache_wb_buffer #(.W(W), .LOG_W(2), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_addr(wb_addr), .wb_line(wb_line),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
`ifdef CACHE_WB_BRESP_CHECK_EN
    .bresp(bresp), .wb_err(wb_err),
`endif
    .busy(busy), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rv, awr, wr, bv;
    logic rr, awv, wv, wl, br, bs, dn;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input logic [32*W-1:0] l, input int k);
    return l[32*k +: 32];
  endfunction

  task automatic burst(input logic [31:0] a, input logic [32*W-1:0] l, input logic [1:0] r);
    wb_addr = a; wb_line = l; bresp = r;
    wb_req_valid = 1; awready = 1; wready = 1; bvalid = 1;
    chk("b_req_ready", wb_req_ready, 1);
    step;
    wb_req_valid = 0;
    chk("b_awvalid", awvalid, 1);
    chk("b_awaddr", awaddr, a & ~32'hf);
    step;
    for (int k = 0; k < W; k++) begin
      chk("b_wvalid", wvalid, 1);
      chk("b_wdata", wdata, word(l, k));
      chk("b_wlast", wlast, k == W - 1);
      step;
    end
    chk("b_bready", bready, 1);
    step;
    chk("b_done", wb_done, 1);
    chk("b_ready_back", wb_req_ready, 1);
    bvalid = 0;
    step;
    chk("b_done_once", wb_done, 0);
  endtask

  vec_t tbl[9];
  logic [32*W-1:0] l1, l2;
  int pat[7];

  initial begin
    tbl[0] = '{1,1,1,1, 1,0,0,0,0,0,0, 32'h0};
    tbl[1] = '{0,1,1,1, 0,1,0,0,0,1,0, 32'h0};
    tbl[2] = '{0,1,1,1, 0,0,1,0,0,1,0, 32'hAAAA_0000};
    tbl[3] = '{0,1,1,1, 0,0,1,0,0,1,0, 32'hBBBB_0001};
    tbl[4] = '{0,1,1,1, 0,0,1,0,0,1,0, 32'hCCCC_0002};
    tbl[5] = '{0,1,1,1, 0,0,1,1,0,1,0, 32'hDDDD_0003};
    tbl[6] = '{0,1,1,1, 0,0,0,0,1,1,0, 32'h0};
    tbl[7] = '{0,1,1,1, 1,0,0,0,0,0,1, 32'h0};
    tbl[8] = '{0,0,0,0, 1,0,0,0,0,0,0, 32'h0};
    pat = '{1,0,0,1,1,0,1};

    #2 resetn = 0;
    step;
    chk("rst_req_ready", wb_req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_done", wb_done, 0);
    @(negedge clk) resetn = 1;
    step;

    wb_addr = 32'h1000_0014;
    wb_line = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    for (int i = 0; i < 9; i++) begin
      wb_req_valid = tbl[i].rv; awready = tbl[i].awr; wready = tbl[i].wr; bvalid = tbl[i].bv;
      chk("t_req_ready", wb_req_ready, tbl[i].rr);
      chk("t_awvalid", awvalid, tbl[i].awv);
      chk("t_wvalid", wvalid, tbl[i].wv);
      chk("t_wlast", wlast, tbl[i].wl);
      chk("t_wstrb", wstrb, tbl[i].wv ? 4'hf : 4'h0);
      chk("t_bready", bready, tbl[i].br);
      chk("t_busy", busy, tbl[i].bs);
      chk("t_done", wb_done, tbl[i].dn);
      if (tbl[i].wv) chk("t_wdata", wdata, tbl[i].wd);
      if (tbl[i].awv) begin
        chk("t_awaddr", awaddr, 32'h1000_0010);
        chk("t_awlen", awlen, 8'd3);
      end
      step;
    end

    l1 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    l2 = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
    wb_addr = 32'h2000_003C; wb_line = l1;
    wb_req_valid = 1; awready = 0; wready = 0; bvalid = 0;
    step;
    wb_req_valid = 0; wb_line = l2; wb_addr = 32'h5000_0000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_awvalid", awvalid, 1);
      chk("bp_awaddr", awaddr, 32'h2000_0030);
      chk("bp_wvalid", wvalid, 0);
      step;
    end
    awready = 1;
    chk("bp_awvalid_acc", awvalid, 1);
    step;
    awready = 0;
    wb_req_valid = 1;
    begin
      int nb = 0;
      for (int i = 0; i < 7; i++) begin
        wready = pat[i][0];
        chk("bp_wvalid", wvalid, 1);
        chk("bp_busy_rdy", wb_req_ready, 0);
        chk("bp_wdata", wdata, word(l1, nb));
        chk("bp_wlast", wlast, nb == W - 1);
        if (pat[i] != 0) nb++;
        step;
      end
    end
    wready = 0;
    chk("bp_after_wvalid", wvalid, 0);
    for (int i = 0; i < 10; i++) begin
      chk("rw_bready", bready, 1);
      chk("rw_busy_rdy", wb_req_ready, 0);
      chk("rw_done", wb_done, 0);
      step;
    end
    bvalid = 1; wb_req_valid = 0;
    chk("rw_bready_hs", bready, 1);
    step;
    bvalid = 0;
    chk("rw_done_pulse", wb_done, 1);
    chk("rw_idle", busy, 0);
    step;
    chk("rw_done_once", wb_done, 0);
    chk("rw_not_captured", busy, 0);

    wb_addr = 32'h3000_0000;
    wb_line = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
    wb_req_valid = 1; awready = 1; wready = 1;
    step;
    wb_req_valid = 0;
    step;
    step;
    step;
    chk("mr_before_wdata", wdata, 32'h7777_0002);
    resetn = 0;
    #1;
    chk("mr_wvalid", wvalid, 0);
    chk("mr_awvalid", awvalid, 0);
    chk("mr_bready", bready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", wb_req_ready, 1);
    chk("mr_wstrb", wstrb, 0);
    @(negedge clk) resetn = 1;
    step;
    burst(32'h4000_0008, {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000}, 2'b00);

`ifdef CACHE_WB_BRESP_CHECK_EN
    chk("err_clean", wb_err, 0);
    burst(32'h6000_0010, {32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000}, 2'b10);
    chk("err_set", wb_err, 1);
    burst(32'h6000_0020, {32'h4321_0003, 32'h4321_0002, 32'h4321_0001, 32'h4321_0000}, 2'b00);
    chk("err_sticky", wb_err, 1);
    resetn = 0;
    #1;
    chk("err_reset", wb_err, 0);
    @(negedge clk) resetn = 1;
    step;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
